wb_apb_bridge: RTL and testbench

Wishbone-classic slave to APB3 master bridge that sits between the management SoC Wishbone port of the user project and APB peripherals such as the 2 KB SRAM macro. It decodes one address window, converts each Wishbone cycle into exactly one APB transfer (SETUP then ACCESS), and returns registered read data with a single-cycle ack. A programmable timeout and an error counter keep a stuck peripheral from hanging the SoC bus.

---
 rtl/wb_apb_bridge.sv | 170 +++++++++++++++++
 tb/tb_wb_apb_bridge.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_apb_bridge.sv
// Wishbone-classic slave to APB3 master bridge: one address window, one APB
// transfer per Wishbone cycle, registered outputs, timeout and error counter.
module wb_apb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          APB_AW    = 12,
  parameter logic [7:0]  TIMEOUT   = 8'd64,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [APB_AW-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  output logic [3:0]        pstrb,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              err_pulse_o,
  output logic [7:0]        err_count_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DONE = 2'd3} state_e;

  state_e              state_q, state_d;
  logic [APB_AW-1:0]   paddr_q, paddr_d;
  logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [31:0]         pwdata_q, pwdata_d, dat_q, dat_d, result_s;
  logic [3:0]          pstrb_q, pstrb_d;
  logic                ack_q, ack_d, err_pulse_q, err_pulse_d, abort_q, abort_d;
  logic [7:0]          err_cnt_q, err_cnt_d, tmo_q, tmo_d;
  logic                hit_s, done_s, err_s;

  assign hit_s = (wbs_adr_i[31:APB_AW] == BASE_ADDR[31:APB_AW]);

  // Next-state and next-output logic; every output is the register of its _d
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    tmo_d       = tmo_q;
    abort_d     = abort_q;
    ack_d       = 1'b0;
    dat_d       = 32'h0000_0000;
    err_pulse_d = 1'b0;
    done_s      = 1'b0;
    err_s       = 1'b0;
    result_s    = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        tmo_d   = 8'd0;
        abort_d = 1'b0;
        if (wbs_cyc_i && wbs_stb_i && hit_s) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          paddr_d  = wbs_adr_i[APB_AW-1:0];
          pwdata_d = wbs_dat_i;
          pwrite_d = wbs_we_i;
          pstrb_d  = wbs_we_i ? wbs_sel_i : 4'b0000;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        abort_d   = abort_q | ~wbs_cyc_i;
      end
      ACCESS: begin
        abort_d = abort_q | ~wbs_cyc_i;
        // pready is checked first so it beats a timeout in the same cycle
        if (pready) begin
          done_s   = 1'b1;
          err_s    = pslverr;
          result_s = pslverr ? ERR_DATA : (pwrite_q ? 32'h0000_0000 : prdata);
        end else if ((TIMEOUT != 8'd0) && (tmo_q == (TIMEOUT - 8'd1))) begin
          done_s   = 1'b1;
          err_s    = 1'b1;
          result_s = ERR_DATA;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
        if (done_s) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          tmo_d       = 8'd0;
          err_pulse_d = err_s;
          if (abort_d) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            ack_d   = 1'b1;
            dat_d   = result_s;
          end
        end else begin
          state_d = ACCESS;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (err_pulse_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 32'h0000_0000;
      pstrb_q     <= 4'b0000;
      tmo_q       <= 8'd0;
      abort_q     <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= 32'h0000_0000;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      tmo_q       <= tmo_d;
      abort_q     <= abort_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign paddr       = paddr_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign err_pulse_o = err_pulse_q;
  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_wb_apb_bridge.sv
// Directed bench for wb_apb_bridge: a table of transfers against a small APB
// slave memory, plus hand-written reset sequences. Two instances differ in TIMEOUT.
module tb_wb_apb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, use_t;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        pready, pslverr;
  logic [31:0] prdata;

  logic        ack_a, ack_b, psel_a, psel_b, pen_a, pen_b, pwr_a, pwr_b, errp_a, errp_b;
  logic [31:0] dat_a, dat_b, pwd_a, pwd_b;
  logic [11:0] padr_a, padr_b;
  logic [3:0]  pstrb_a, pstrb_b;
  logic [7:0]  cnt_a, cnt_b;

  logic        m_ack, m_psel, m_pen, m_pwr, m_errp;
  logic [31:0] m_dat, m_pwd;
  logic [11:0] m_padr;
  logic [3:0]  m_pstrb;
  logic [7:0]  m_cnt;
  logic [31:0] mem [16];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_apb_bridge dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc & ~use_t), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_a), .wbs_dat_o(dat_a),
    .paddr(padr_a), .psel(psel_a), .penable(pen_a), .pwrite(pwr_a), .pwdata(pwd_a),
    .pstrb(pstrb_a), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .err_pulse_o(errp_a), .err_count_o(cnt_a));

  wb_apb_bridge #(.TIMEOUT(8'd4)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc & use_t), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_b), .wbs_dat_o(dat_b),
    .paddr(padr_b), .psel(psel_b), .penable(pen_b), .pwrite(pwr_b), .pwdata(pwd_b),
    .pstrb(pstrb_b), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .err_pulse_o(errp_b), .err_count_o(cnt_b));

  assign m_ack   = use_t ? ack_b   : ack_a;
  assign m_dat   = use_t ? dat_b   : dat_a;
  assign m_psel  = use_t ? psel_b  : psel_a;
  assign m_pen   = use_t ? pen_b   : pen_a;
  assign m_pwr   = use_t ? pwr_b   : pwr_a;
  assign m_pwd   = use_t ? pwd_b   : pwd_a;
  assign m_padr  = use_t ? padr_b  : padr_a;
  assign m_pstrb = use_t ? pstrb_b : pstrb_a;
  assign m_errp  = use_t ? errp_b  : errp_a;
  assign m_cnt   = use_t ? cnt_b   : cnt_a;
  assign prdata  = mem[m_padr[5:2]];

  // APB slave memory: byte-strobed write on a completing write ACCESS
  always @(posedge clk) begin
    if (m_psel && m_pen && pready && m_pwr) begin
      for (int b = 0; b < 4; b++) begin
        if (m_pstrb[b]) mem[m_padr[5:2]][8*b +: 8] <= m_pwd[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic        use_t;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          wt;        // ACCESS cycles with pready low (99 = never ready)
    logic        slverr;
    int          abort_at;  // cycle in which cyc drops, -1 = never
    int          e_ack;     // -1 = no ack expected
    logic [31:0] e_dat;
    int          e_psel;
    int          e_pen;
    logic [31:0] e_paddr;   // all ones = no ACCESS phase seen
    logic [3:0]  e_pstrb;
    int          e_errp;
    logic [7:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(logic ut, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                              int wt, logic se, int ab, int eack, logic [31:0] edat, int eps,
                              int epe, logic [31:0] epa, logic [3:0] est, int eer, logic [7:0] ec);
    vec_t v;
    v.use_t = ut; v.we = w; v.adr = a; v.dat = d; v.sel = s; v.wt = wt; v.slverr = se;
    v.abort_at = ab; v.e_ack = eack; v.e_dat = edat; v.e_psel = eps; v.e_pen = epe;
    v.e_paddr = epa; v.e_pstrb = est; v.e_errp = eer; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int ack_cyc = -1, psel_cyc = -1, pen_cyc = -1, acks = 0, errps = 0;
    logic [31:0] ack_dat = 32'h0, cap_paddr = 32'hFFFF_FFFF, cap_pwd = 32'h0;
    logic [3:0] cap_pstrb = 4'hF;
    logic cap_pwr = 1'b0, seen = 1'b0, stable = 1'b1, leak = 1'b0, last_psel = 1'b0;
    use_t = v.use_t; we = v.we; adr = v.adr; wdat = v.dat; sel = v.sel;
    cyc = 1'b1; stb = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == v.abort_at) begin cyc = 1'b0; stb = 1'b0; end
      pready  = (v.wt != 99) && (c >= 2 + v.wt);
      pslverr = v.slverr & pready;
      @(negedge clk);
      if (m_psel && psel_cyc < 0) psel_cyc = c;
      if (m_pen && pen_cyc < 0) pen_cyc = c;
      if (m_psel && m_pen) begin
        if (!seen) begin
          seen = 1'b1; cap_paddr = {20'h0, m_padr}; cap_pstrb = m_pstrb;
          cap_pwr = m_pwr; cap_pwd = m_pwd;
        end else if ({20'h0, m_padr} != cap_paddr || m_pstrb != cap_pstrb ||
                     m_pwr != cap_pwr || m_pwd != cap_pwd) begin
          stable = 1'b0;
        end
      end
      if (m_ack) begin acks++; ack_cyc = c; ack_dat = m_dat; end
      if (!m_ack && m_dat != 32'h0) leak = 1'b1;
      if (m_errp) errps++;
      last_psel = m_psel;
      if (ack_cyc >= 0 && c >= ack_cyc + 2) break;
      @(posedge clk); #1;
      if (m_ack) begin cyc = 1'b0; stb = 1'b0; end
    end
    check($sformatf("v%0d ack_cycle", idx), ack_cyc, v.e_ack);
    check($sformatf("v%0d ack_data", idx), ack_dat, v.e_dat);
    check($sformatf("v%0d ack_count", idx), acks, (v.e_ack >= 0) ? 1 : 0);
    check($sformatf("v%0d psel_cycle", idx), psel_cyc, v.e_psel);
    check($sformatf("v%0d penable_cycle", idx), pen_cyc, v.e_pen);
    check($sformatf("v%0d paddr", idx), cap_paddr, v.e_paddr);
    check($sformatf("v%0d pstrb", idx), {28'h0, cap_pstrb}, {28'h0, v.e_pstrb});
    check($sformatf("v%0d apb_stable", idx), {31'h0, stable}, 32'd1);
    check($sformatf("v%0d dat_without_ack", idx), {31'h0, leak}, 32'd0);
    check($sformatf("v%0d err_pulses", idx), errps, v.e_errp);
    check($sformatf("v%0d err_count", idx), {24'h0, m_cnt}, {24'h0, v.e_cnt});
    check($sformatf("v%0d psel_end", idx), {31'h0, last_psel}, 32'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; pready = 1'b0; pslverr = 1'b0;
  endtask

  task automatic check_zero(input string nm, input logic b);
    logic [31:0] ctl;
    if (b) ctl = {19'h0, ack_b, psel_b, pen_b, pwr_b, errp_b, pstrb_b, cnt_b};
    else   ctl = {19'h0, ack_a, psel_a, pen_a, pwr_a, errp_a, pstrb_a, cnt_a};
    check({nm, "_ctl"},   ctl, 32'h0);
    check({nm, "_dat"},   b ? dat_b : dat_a, 32'h0);
    check({nm, "_paddr"}, {20'h0, b ? padr_b : padr_a}, 32'h0);
    check({nm, "_pwdata"}, b ? pwd_b : pwd_a, 32'h0);
  endtask

  vec_t vecs [11];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; use_t = 1'b0; sel = 4'h0;
    adr = 32'h0; wdat = 32'h0; pready = 1'b0; pslverr = 1'b0;

    //           ut   we    adr           dat           sel    wt se  ab  ack e_dat         ps  pe  paddr         strb  er cnt
    vecs[0]  = mk(1'b0, 1'b1, 32'h3000_0010, 32'hA5A5_1234, 4'hF, 0, 1'b0, -1, 3, 32'h0,         1,  2, 32'h010,       4'hF, 0, 8'd0);
    vecs[1]  = mk(1'b0, 1'b0, 32'h3000_0010, 32'h0,         4'hF, 0, 1'b0, -1, 3, 32'hA5A5_1234, 1,  2, 32'h010,       4'h0, 0, 8'd0);
    vecs[2]  = mk(1'b0, 1'b1, 32'h3000_0024, 32'h1122_3344, 4'h3, 5, 1'b0, -1, 8, 32'h0,         1,  2, 32'h024,       4'h3, 0, 8'd0);
    vecs[3]  = mk(1'b0, 1'b0, 32'h3000_0024, 32'h0,         4'hF, 2, 1'b0, -1, 5, 32'h0000_3344, 1,  2, 32'h024,       4'h0, 0, 8'd0);
    vecs[4]  = mk(1'b0, 1'b0, 32'h3000_0010, 32'h0,         4'hF, 0, 1'b1, -1, 3, 32'hDEAD_BEEF, 1,  2, 32'h010,       4'h0, 1, 8'd1);
    vecs[5]  = mk(1'b0, 1'b0, 32'h2000_0000, 32'h0,         4'hF, 0, 1'b0, -1, -1, 32'h0,        -1, -1, 32'hFFFF_FFFF, 4'hF, 0, 8'd1);
    vecs[6]  = mk(1'b0, 1'b1, 32'h3000_1000, 32'h5555_5555, 4'hF, 0, 1'b0, -1, -1, 32'h0,        -1, -1, 32'hFFFF_FFFF, 4'hF, 0, 8'd1);
    vecs[7]  = mk(1'b1, 1'b0, 32'h3000_0010, 32'h0,         4'hF, 99, 1'b0, -1, 6, 32'hDEAD_BEEF, 1, 2, 32'h010,       4'h0, 1, 8'd1);
    vecs[8]  = mk(1'b1, 1'b0, 32'h3000_0010, 32'h0,         4'hF, 3, 1'b0, -1, 6, 32'hA5A5_1234, 1,  2, 32'h010,       4'h0, 0, 8'd1);
    vecs[9]  = mk(1'b0, 1'b0, 32'h3000_0010, 32'h0,         4'hF, 3, 1'b0, 3, -1, 32'h0,         1,  2, 32'h010,       4'h0, 0, 8'd1);
    vecs[10] = mk(1'b0, 1'b1, 32'h3000_0FFC, 32'hCAFE_F00D, 4'hC, 0, 1'b0, -1, 3, 32'h0,         1,  2, 32'hFFC,       4'hC, 0, 8'd1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset_a", 1'b0);
    check_zero("reset_b", 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);
    check("mem_partial_write", mem[9], 32'h0000_3344);
    check("mem_top_write", mem[15], 32'hCAFE_0000);

    // Reset in the middle of an ACCESS phase that would otherwise never finish
    use_t = 1'b0; we = 1'b0; adr = 32'h3000_0010; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    pready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("midrst_in_access", {30'h0, psel_a, pen_a}, 32'h3);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("midrst_a", 1'b0);
    @(posedge clk); #1;
    run_vec(11, mk(1'b0, 1'b0, 32'h3000_0010, 32'h0, 4'hF, 0, 1'b0, -1, 3, 32'hA5A5_1234,
                   1, 2, 32'h010, 4'h0, 0, 8'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
